// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and the architectural
// register indices the control FSM refers to by name.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

  // One-hot decode of a register index; used for busy-bit set/clear masks.
  function automatic logic [(1<<REG_ADDR_W)-1:0] reg_onehot(input reg_addr_t a);
    logic [(1<<REG_ADDR_W)-1:0] v;
    v = {{((1<<REG_ADDR_W)-1){1'b0}}, 1'b1} << a;
    return v;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array for the register file: one pending-producer flag per register,
// set by issue, cleared by writeback, with a global OR for drain/flush.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH    = REG_ADDR_W,
  parameter int ZERO_REG = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_set,
  input  logic [DEPTH-1:0]      i_set_a,
  input  logic                  i_clr,
  input  logic [DEPTH-1:0]      i_clr_a,
  output logic [(1<<DEPTH)-1:0] o_busy,
  output logic                  o_any_busy
);

  localparam int NREG = 1 << DEPTH;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_nxt;

  // Set beats clear on the same register: a newer producer supersedes the one writing back.
  always_comb begin
    w_set_mask = {NREG{1'b0}};
    w_clr_mask = {NREG{1'b0}};
    if (i_set) begin
      w_set_mask = {{(NREG-1){1'b0}}, 1'b1} << i_set_a;
    end else begin
      w_set_mask = {NREG{1'b0}};
    end
    if (i_clr) begin
      w_clr_mask = {{(NREG-1){1'b0}}, 1'b1} << i_clr_a;
    end else begin
      w_clr_mask = {NREG{1'b0}};
    end
    if (ZR) begin
      w_set_mask[0] = 1'b0;
    end else begin
      w_set_mask[0] = w_set_mask[0];
    end
    w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_any_busy = |r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Resettable multi-port MIPS register file with optional write-to-read bypass
// and an integrated busy-bit scoreboard for stall decisions.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int DEPTH      = REG_ADDR_W,
  parameter int DATA_WIDTH = WORD_W,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         WE3,
  input  logic [DEPTH-1:0]             A3,
  input  logic [DATA_WIDTH-1:0]        WD3,
  input  logic [NUM_RD*DEPTH-1:0]      RA,
  output logic [NUM_RD*DATA_WIDTH-1:0] RD,
  output logic [NUM_RD-1:0]            RBUSY,
  input  logic                         SB_SET,
  input  logic [DEPTH-1:0]             SB_A,
  output logic                         ANY_BUSY
);

  localparam int NREG = 1 << DEPTH;
  localparam bit ZR   = (ZERO_REG != 0);
  localparam bit BP   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_file [NREG];
  logic [NREG-1:0]       w_busy;
  logic                  w_wr_en;
  logic                  w_any_busy;

  // A write to the hardwired zero register is dropped entirely, including its busy clear.
  always_comb begin
    if (ZR && (A3 == {DEPTH{1'b0}})) begin
      w_wr_en = 1'b0;
    end else begin
      w_wr_en = WE3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_file[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_wr_en) begin
      r_file[A3] <= WD3;
    end else begin
      r_file[A3] <= r_file[A3];
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (SB_SET),
    .i_set_a    (SB_A),
    .i_clr      (w_wr_en),
    .i_clr_a    (A3),
    .o_busy     (w_busy),
    .o_any_busy (w_any_busy)
  );

  assign ANY_BUSY = w_any_busy;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [DEPTH-1:0]      w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_rbusy;

    assign w_ra = RA[g*DEPTH +: DEPTH];

    // Gating on rst_n keeps a bypassed WD3 from leaking out while the file is held clear.
    always_comb begin
      if (!rst_n) begin
        w_rd    = {DATA_WIDTH{1'b0}};
        w_rbusy = 1'b0;
      end else if (ZR && (w_ra == {DEPTH{1'b0}})) begin
        w_rd    = {DATA_WIDTH{1'b0}};
        w_rbusy = 1'b0;
      end else if (BP && w_wr_en && (A3 == w_ra)) begin
        w_rd    = WD3;
        w_rbusy = 1'b0;
      end else begin
        w_rd    = r_file[w_ra];
        w_rbusy = w_busy[w_ra];
      end
    end

    assign RD[g*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign RBUSY[g]                       = w_rbusy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 4-port bypassing instance and a 2-port
// non-bypassing instance share the write/scoreboard inputs.
module tb_regfile_sb;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        WE3    = 1'b0;
  logic        SB_SET = 1'b0;
  logic [4:0]  A3     = 5'd0;
  logic [4:0]  SB_A   = 5'd0;
  logic [31:0] WD3    = 32'd0;

  logic [19:0]  ra_a = 20'd0;
  logic [127:0] rd_a;
  logic [3:0]   rbusy_a;
  logic         any_a;

  logic [9:0]  ra_b = 10'd0;
  logic [63:0] rd_b;
  logic [1:0]  rbusy_b;
  logic        any_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DEPTH(5), .DATA_WIDTH(32), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3), .RA(ra_a), .RD(rd_a),
    .RBUSY(rbusy_a), .SB_SET(SB_SET), .SB_A(SB_A), .ANY_BUSY(any_a)
  );

  regfile_sb #(.DEPTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3), .RA(ra_b), .RD(rd_b),
    .RBUSY(rbusy_b), .SB_SET(SB_SET), .SB_A(SB_A), .ANY_BUSY(any_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    WE3    = 1'b0;
    SB_SET = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_ra [4];

    // reset state
    ra_a = {5'd3, 5'd2, 5'd1, 5'd5};
    ra_b = {5'd1, 5'd5};
    #3;
    chk("rst_rd_a0", rd_a[31:0], 32'd0);
    chk("rst_rd_b0", rd_b[31:0], 32'd0);
    chk("rst_any_a", {31'd0, any_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // write r5 and set its busy bit in the same cycle; set wins
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; SB_SET = 1'b1; SB_A = 5'd5;
    settle();
    chk("wr5_bypass_a", rd_a[31:0], 32'hDEADBEEF);
    chk("wr5_bypass_busy_a", {31'd0, rbusy_a[0]}, 32'd0);
    chk("wr5_nobypass_b", rd_b[31:0], 32'd0);
    tick();
    idle();
    settle();
    chk("wr5_after_b", rd_b[31:0], 32'hDEADBEEF);
    chk("wr5_busy_b", {31'd0, rbusy_b[0]}, 32'd1);
    chk("wr5_any_b", {31'd0, any_b}, 32'd1);
    tick();

    // asynchronous reset pulse between edges
    rst_n = 1'b0;
    settle();
    chk("rstpulse_rd_a", rd_a[31:0], 32'd0);
    chk("rstpulse_rd_b", rd_b[31:0], 32'd0);
    chk("rstpulse_any_a", {31'd0, any_a}, 32'd0);
    chk("rstpulse_any_b", {31'd0, any_b}, 32'd0);
    chk("rstpulse_rbusy_b", {31'd0, rbusy_b[0]}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("postrst_rd_b", rd_b[31:0], 32'd0);

    // zero register ignores write and set
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; SB_SET = 1'b1; SB_A = 5'd0;
    ra_a = 20'd0; ra_b = 10'd0;
    settle();
    chk("zero_bypass_a", rd_a[31:0], 32'd0);
    chk("zero_bypass_busy_a", {31'd0, rbusy_a[0]}, 32'd0);
    tick();
    idle();
    settle();
    chk("zero_rd_b", rd_b[31:0], 32'd0);
    chk("zero_rbusy_b", {31'd0, rbusy_b[0]}, 32'd0);
    chk("zero_any_a", {31'd0, any_a}, 32'd0);
    chk("zero_any_b", {31'd0, any_b}, 32'd0);
    tick();

    // fill r1..r31 with their own index
    for (int i = 1; i < 32; i++) begin
      WE3 = 1'b1; A3 = 5'(i); WD3 = 32'(i);
      ra_a = {4{5'(i)}};
      settle();
      chk("fill_bypass_a", rd_a[31:0], 32'(i));
      tick();
    end
    idle();

    // port sweep: distinct then identical addresses
    exp_ra[0] = 5'd3; exp_ra[1] = 5'd17; exp_ra[2] = 5'd29; exp_ra[3] = 5'd31;
    ra_a = {exp_ra[3], exp_ra[2], exp_ra[1], exp_ra[0]};
    ra_b = {5'd31, 5'd1};
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("sweep_distinct_a", rd_a[k*32 +: 32], {27'd0, exp_ra[k]});
    end
    chk("sweep_b0", rd_b[31:0], 32'd1);
    chk("sweep_b1", rd_b[63:32], 32'd31);
    ra_a = {4{5'd20}};
    settle();
    for (int k = 0; k < 4; k++) begin
      chk("sweep_same_a", rd_a[k*32 +: 32], 32'd20);
    end
    tick();

    // bypass vs. no-bypass on r7 with r8 on the second port
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h1234;
    ra_a = {5'd0, 5'd0, 5'd8, 5'd7};
    ra_b = {5'd8, 5'd7};
    settle();
    chk("byp_rd0_a", rd_a[31:0], 32'h1234);
    chk("byp_rd1_a", rd_a[63:32], 32'd8);
    chk("nobyp_rd0_b", rd_b[31:0], 32'd7);
    chk("nobyp_rd1_b", rd_b[63:32], 32'd8);
    tick();
    idle();
    settle();
    chk("nobyp_next_b", rd_b[31:0], 32'h1234);
    tick();

    // scoreboard set on r9, then write r9
    SB_SET = 1'b1; SB_A = 5'd9;
    ra_a = {4{5'd9}}; ra_b = {2{5'd9}};
    settle();
    chk("sb_pre_a", {31'd0, rbusy_a[0]}, 32'd0);
    chk("sb_pre_b", {31'd0, rbusy_b[0]}, 32'd0);
    tick();
    idle();
    settle();
    chk("sb_set_a", {31'd0, rbusy_a[0]}, 32'd1);
    chk("sb_set_b", {31'd0, rbusy_b[0]}, 32'd1);
    chk("sb_any_a", {31'd0, any_a}, 32'd1);
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h99;
    settle();
    chk("sb_wr_byp_a", {31'd0, rbusy_a[0]}, 32'd0);
    chk("sb_wr_any_a", {31'd0, any_a}, 32'd1);
    chk("sb_wr_nobyp_b", {31'd0, rbusy_b[0]}, 32'd1);
    tick();
    idle();
    settle();
    chk("sb_clr_b", {31'd0, rbusy_b[0]}, 32'd0);
    chk("sb_clr_any_a", {31'd0, any_a}, 32'd0);
    chk("sb_clr_any_b", {31'd0, any_b}, 32'd0);
    chk("sb_rd_b", rd_b[31:0], 32'h99);
    tick();

    // set/write collision on r3, then set and write to different registers
    SB_SET = 1'b1; SB_A = 5'd3;
    tick();
    SB_SET = 1'b1; SB_A = 5'd3; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h55;
    ra_b = {5'd10, 5'd3};
    tick();
    idle();
    settle();
    chk("coll_rd_b", rd_b[31:0], 32'h55);
    chk("coll_busy_b", {31'd0, rbusy_b[0]}, 32'd1);
    SB_SET = 1'b1; SB_A = 5'd10; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h66;
    tick();
    idle();
    settle();
    chk("diff_rd3_b", rd_b[31:0], 32'h66);
    chk("diff_busy3_b", {31'd0, rbusy_b[0]}, 32'd0);
    chk("diff_busy10_b", {31'd0, rbusy_b[1]}, 32'd1);
    tick();

    // reset asserted with a write pending at the next edge
    WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hABC;
    ra_b = {5'd10, 5'd12};
    #1;
    rst_n = 1'b0;
    tick();
    idle();
    rst_n = 1'b1;
    settle();
    chk("midrst_rd12_b", rd_b[31:0], 32'd0);
    chk("midrst_busy10_b", {31'd0, rbusy_b[1]}, 32'd0);
    chk("midrst_any_b", {31'd0, any_b}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
